// File: rtl/pmem_responder.sv
// pmem_responder: responder end of the 128-bit line-granular pmem bus.
// It accepts one read or write line request and waits a programmable latency.
// Then it performs the access on an internal line store and pulses pmem_resp.
module pmem_responder #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         proto_err
);

    localparam int unsigned CW    = $clog2(LATENCY + 1);
    localparam int unsigned DEPTH = 1 << INDEX_BITS;
    localparam int unsigned LW    = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_count;
    logic [CW-1:0]           w_count_nxt;
    logic                    r_op_write;
    logic [INDEX_BITS-1:0]   r_index;
    logic [LW-1:0]           r_wdata;
    logic [LW-1:0]           r_rdata;
    logic                    r_resp;
    logic                    r_proto_err;
    logic [LW-1:0]           r_mem [DEPTH];

    logic                    w_accept;
    logic                    w_both;
    logic [INDEX_BITS-1:0]   w_addr_index;
    logic [INDEX_BITS-1:0]   w_rd_index;
    logic                    w_op_write_eff;
    logic                    w_enter_resp;
    logic                    w_unused_addr;

    // Line index from the byte address; offset and high bits alias away
    assign w_addr_index  = pmem_address[INDEX_BITS+3:4];
    assign w_unused_addr = ^{pmem_address[3:0], pmem_address[15:INDEX_BITS+4]};

    // With LATENCY==1 RESP is entered straight from IDLE, so use live inputs then
    assign w_rd_index     = (r_state == IDLE) ? w_addr_index : r_index;
    assign w_op_write_eff = (r_state == IDLE) ? pmem_write   : r_op_write;
    assign w_enter_resp   = (w_state_nxt == RESP) && (r_state != RESP);

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_accept    = 1'b0;
        w_both      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (pmem_read ^ pmem_write) begin
                    w_accept    = 1'b1;
                    w_count_nxt = CW'(LATENCY - 1);
                    w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
                end else if (pmem_read && pmem_write) begin
                    w_both = 1'b1;
                end
            end
            BUSY: begin
                w_count_nxt = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register, request latches and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_op_write  <= 1'b0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_resp      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_resp      <= (w_state_nxt == RESP);
            r_proto_err <= r_proto_err | w_both;
            if (w_accept) begin
                r_op_write <= pmem_write;
                r_index    <= w_addr_index;
                r_wdata    <= pmem_wdata;
            end
            if (w_enter_resp && !w_op_write_eff) begin
                r_rdata <= r_mem[w_rd_index];
            end
        end
    end

    // Line store: write commits on the edge leaving RESP, contents survive reset
    always_ff @(posedge clk) begin
        if ((r_state == RESP) && r_op_write) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    assign pmem_rdata = r_rdata;
    assign pmem_resp  = r_resp;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_pmem_responder.sv
// Testbench for pmem_responder: randomized line traffic against a line-array
// reference model, with a scoreboard queue drained by an independent monitor.
module tb_pmem_responder;

    localparam int unsigned LAT = 10;
    localparam int unsigned IB  = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         resp;
    logic         perr;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(LAT), .INDEX_BITS(IB)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (rd),
        .pmem_write   (wr),
        .pmem_address (addr),
        .pmem_wdata   (wdata),
        .pmem_rdata   (rdata),
        .pmem_resp    (resp),
        .proto_err    (perr)
    );

    typedef struct {
        bit           is_read;
        logic [127:0] data;
    } exp_t;

    exp_t         sbq[$];
    logic [127:0] model_mem [int];
    logic [127:0] model_last;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int idx_of(input logic [15:0] a);
        return int'(a[IB+3:4]);
    endfunction

    // Reference model: the line store is an array indexed by line number
    task automatic push_exp(input bit w, input logic [15:0] a, input logic [127:0] d);
        exp_t e;
        int   i;
        i = idx_of(a);
        if (!w) begin
            e.is_read  = 1'b1;
            e.data     = model_mem.exists(i) ? model_mem[i] : '0;
            model_last = e.data;
        end else begin
            e.is_read    = 1'b0;
            e.data       = model_last;
            model_mem[i] = d;
        end
        sbq.push_back(e);
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        for (int i = 1; i <= 4 * LAT; i++) begin
            @(posedge clk);
            #1;
            if (resp) begin
                n = i;
                break;
            end
        end
        if (n == 0 && sbq.size() > 0) void'(sbq.pop_back());
    endtask

    task automatic do_txn(input bit w, input logic [15:0] a, input logic [127:0] d,
                          input string name);
        int n;
        @(negedge clk);
        rd = !w; wr = w; addr = a; wdata = d;
        push_exp(w, a, d);
        wait_resp(n);
        check(n == LAT, {name, "_latency"}, 128'(n), 128'(LAT));
        rd = 1'b0; wr = 1'b0;
        @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_last = '0;
        check(perr == 1'b0, "reset_proto_err", 128'(perr), 128'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every response must match the head of the scoreboard
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev = 1'b0;
                continue;
            end
            if (resp) begin
                check(!prev, "resp_single_cycle", 128'(prev), 128'(0));
                if (sbq.size() == 0) begin
                    check(1'b0, "unexpected_resp", 128'(resp), 128'(0));
                end else begin
                    e = sbq.pop_front();
                    check(rdata === e.data, e.is_read ? "rdata_read" : "rdata_hold",
                          rdata, e.data);
                end
            end
            prev = resp;
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int           n;
        int           cnt;
        bit           w;
        logic [15:0]  a;
        logic [127:0] d;
        logic [127:0] line1;

        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        model_last = '0;
        repeat (3) @(posedge clk);
        #1;
        check(resp == 1'b0, "reset_resp", 128'(resp), 128'(0));
        check(rdata == '0, "reset_rdata", rdata, '0);
        check(perr == 1'b0, "reset_perr", 128'(perr), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Seed lines 0..15 so every later read has a known model value
        for (int i = 0; i < 16; i++) begin
            do_txn(1'b1, 16'(i << 4), {$urandom, $urandom, $urandom, $urandom}, "seed");
        end

        // Directed write/read of one line
        line1 = 128'h0123456789abcdef0123456789abcdef;
        do_txn(1'b1, 16'h0120, line1, "t1_wr");
        do_txn(1'b0, 16'h0120, '0, "t1_rd");

        // Read held across its response starts a second read after one idle cycle
        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 16'h0030;
        push_exp(1'b0, 16'h0030, '0);
        wait_resp(n);
        check(n == LAT, "t3_first_latency", 128'(n), 128'(LAT));
        push_exp(1'b0, 16'h0030, '0);
        wait_resp(n);
        check(n == LAT + 1, "t3_b2b_gap", 128'(n), 128'(LAT + 1));
        rd = 1'b0;
        @(posedge clk);

        // Write then immediate read of the same line returns the new data
        d = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; addr = 16'h0050; wdata = d;
        push_exp(1'b1, 16'h0050, d);
        wait_resp(n);
        check(n == LAT, "t3_wr_latency", 128'(n), 128'(LAT));
        wr = 1'b0; rd = 1'b1;
        push_exp(1'b0, 16'h0050, '0);
        wait_resp(n);
        check(n == LAT + 1, "t3_raw_gap", 128'(n), 128'(LAT + 1));
        rd = 1'b0;
        @(posedge clk);

        // Read and write together in IDLE is a protocol error, no transaction
        @(negedge clk);
        rd = 1'b1; wr = 1'b1; addr = 16'h0060;
        cnt = 0;
        repeat (2 * LAT) begin
            @(posedge clk);
            #1;
            if (resp) cnt++;
        end
        check(cnt == 0, "t4_no_resp", 128'(cnt), 128'(0));
        check(perr == 1'b1, "t4_proto_err", 128'(perr), 128'(1));
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        do_txn(1'b0, 16'h0120, '0, "t4_rd");
        check(perr == 1'b1, "t4_proto_err_sticky", 128'(perr), 128'(1));
        pulse_reset();

        // Reset mid-write aborts it: no response, line keeps old contents
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; addr = 16'h0040;
        wdata = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1; wr = 1'b0;
        #1;
        model_last = '0;
        check(resp == 1'b0, "t5_resp_after_rst", 128'(resp), 128'(0));
        check(rdata == '0, "t5_rdata_after_rst", rdata, '0);
        check(perr == 1'b0, "t5_perr_after_rst", 128'(perr), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * LAT) @(posedge clk);
        do_txn(1'b0, 16'h0040, '0, "t5_rd");

        // Aliasing: upper address bits and byte offset are ignored
        d = {$urandom, $urandom, $urandom, $urandom};
        do_txn(1'b1, 16'h1010, d, "t6_wr");
        do_txn(1'b0, 16'h0010, '0, "t6_rd_alias");
        do_txn(1'b0, 16'h1018, '0, "t6_rd_offset");

        // Random traffic over lines 0..15 with random alias and offset bits
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            a = {4'($urandom), 4'h0, 4'($urandom), 4'($urandom)};
            d = {$urandom, $urandom, $urandom, $urandom};
            do_txn(w, a, d, "rand");
        end

        repeat (3) @(posedge clk);
        #1;
        check(sbq.size() == 0, "scoreboard_drained", 128'(sbq.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
